fpga_msg_outbox: RTL and testbench

FPGA_MSG_OUTBOX -- requirements
Module: fpga_msg_outbox

---
 rtl/fpga_msg_outbox_pkg.sv | 15 +
 rtl/outbox_fifo_mem.sv | 30 +++
 rtl/fpga_msg_outbox.sv | 112 +++++++++++
 tb/tb_fpga_msg_outbox.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_msg_outbox_pkg.sv
// Shared constants and types for the FPGA message outbox.
// The drain-FSM encodings are fixed so outbox_state can drive LEDs directly.
package fpga_msg_outbox_pkg;

   localparam logic [1:0] OUTBOX_IDLE  = 2'd0;
   localparam logic [1:0] OUTBOX_SEND  = 2'd1;
   localparam logic [1:0] OUTBOX_STALL = 2'd2;

   typedef enum logic [1:0] {
      StIdle  = OUTBOX_IDLE,
      StSend  = OUTBOX_SEND,
      StStall = OUTBOX_STALL
   } outbox_state_e;

endpackage

// File: rtl/outbox_fifo_mem.sv
// Simple dual-port RAM with a registered read port; no reset on storage so it
// maps onto distributed RAM plus an output register.
module outbox_fifo_mem #(
   parameter int unsigned Width = 32,
   parameter int unsigned AddrW = 4
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [Width-1:0] rd_data_o
);

   logic [Width-1:0] mem_q [2**AddrW];
   logic [Width-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fpga_msg_outbox.sv
// Buffers upstream FPGA messages and drains them into a crossbar FIFO,
// stalling on xb_wr_full and raising registered backpressure with slack.
module fpga_msg_outbox
   import fpga_msg_outbox_pkg::*;
#(
   parameter int unsigned XB_SIZE    = 32,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned SLACK      = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               fpga_msg_valid,
   input  logic [XB_SIZE-1:0] fpga_msg,
   output logic               fpga_msg_full,
   input  logic               xb_wr_full,
   output logic               xb_wr_en,
   output logic [XB_SIZE-1:0] xb_wr_data,
   output logic               overflow,
   output logic [31:0]        msg_count,
   output logic [1:0]         outbox_state
);

   localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
   localparam int unsigned Thresh = Depth - SLACK;
   localparam logic [DEPTH_LOG2:0]   DepthCnt   = Depth[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   FullThresh = Thresh[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   CntOne     = 1;
   localparam logic [DEPTH_LOG2-1:0] PtrOne     = 1;

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   outbox_state_e         state_q, state_d;
   logic                  wr_en_q, wr_en_d;
   logic                  full_q, full_d;
   logic                  overflow_q, overflow_d;
   logic [31:0]           msg_count_q, msg_count_d;
   logic                  accept;
   logic                  pop;

   always_comb begin
      accept = fpga_msg_valid && (count_q < DepthCnt);
      pop    = (count_q != '0) && !xb_wr_full;

      wr_ptr_d = accept ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

      case ({accept, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      // Every state shares the same exits: stall on a blocked non-empty
      // buffer, send whenever an entry can go out, otherwise idle.
      if ((count_q != '0) && xb_wr_full) begin
         state_d = StStall;
      end else if (pop) begin
         state_d = StSend;
      end else begin
         state_d = StIdle;
      end

      wr_en_d     = pop;
      full_d      = (count_d >= FullThresh);
      overflow_d  = overflow_q || (fpga_msg_valid && (count_q == DepthCnt));
      msg_count_d = msg_count_q + {31'd0, wr_en_q};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= StIdle;
         wr_en_q     <= 1'b0;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         msg_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         msg_count_q <= msg_count_d;
      end
   end

   // The RAM read register doubles as the xb_wr_data output register.
   outbox_fifo_mem #(
      .Width (XB_SIZE),
      .AddrW (DEPTH_LOG2)
   ) u_mem (
      .clk_i     (CLK),
      .wr_en_i   (accept),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (fpga_msg),
      .rd_en_i   (pop),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (xb_wr_data)
   );

   assign fpga_msg_full = full_q;
   assign xb_wr_en      = wr_en_q;
   assign overflow      = overflow_q;
   assign msg_count     = msg_count_q;
   assign outbox_state  = state_q;

endmodule

// File: tb/tb_fpga_msg_outbox.sv
// Directed self-checking bench for fpga_msg_outbox.
module tb_fpga_msg_outbox;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        fpga_msg_valid = 1'b0;
   logic [31:0] fpga_msg = '0;
   logic        fpga_msg_full;
   logic        xb_wr_full = 1'b0;
   logic        xb_wr_en;
   logic [31:0] xb_wr_data;
   logic        overflow;
   logic [31:0] msg_count;
   logic [1:0]  outbox_state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int w = 0;

   logic [31:0] got_q[$];
   int          got_cyc[$];
   bit          watch = 1'b0;
   logic        prev_full = 1'b0;
   logic [1:0]  prev_state = 2'd0;
   int          viol = 0;
   int          n_alt = 0;

   fpga_msg_outbox #(
      .XB_SIZE    (32),
      .DEPTH_LOG2 (4),
      .SLACK      (2)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .fpga_msg_valid (fpga_msg_valid),
      .fpga_msg       (fpga_msg),
      .fpga_msg_full  (fpga_msg_full),
      .xb_wr_full     (xb_wr_full),
      .xb_wr_en       (xb_wr_en),
      .xb_wr_data     (xb_wr_data),
      .overflow       (overflow),
      .msg_count      (msg_count),
      .outbox_state   (outbox_state)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (xb_wr_en) begin
         got_q.push_back(xb_wr_data);
         got_cyc.push_back(cyc);
      end
      if (watch) begin
         if (prev_full && xb_wr_en) viol++;
         if (prev_state == 2'd1 && outbox_state == 2'd2) n_alt++;
      end
      prev_full  = xb_wr_full;
      prev_state = outbox_state;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < got_cyc.size()) ? got_cyc[i] : -1000;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      fpga_msg_valid = 1'b1;
      fpga_msg       = v;
      step(1);
      fpga_msg_valid = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      fpga_msg_valid = 1'b0;
      step(2);
      RESET = 1'b0;
   endtask

   task automatic clear_got();
      got_q.delete();
      got_cyc.delete();
   endtask

   initial begin
      do_reset();
      @(negedge CLK);
      check_eq("rst_wr_en", 32'(xb_wr_en), 32'd0);
      check_eq("rst_count", msg_count, 32'd0);
      check_eq("rst_full", 32'(fpga_msg_full), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      check_eq("rst_state", 32'(outbox_state), 32'd0);

      // Five back-to-back messages, free-flowing downstream
      step(1);
      clear_got();
      w = cyc;
      for (int i = 1; i <= 5; i++) push(32'(i));
      step(8);
      check_eq("b2b_n", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) check_eq("b2b_data", got_at(i), 32'(i + 1));
      check_eq("b2b_lat", 32'(cyc_at(0) - w), 32'd2);
      check_eq("b2b_consec", 32'(cyc_at(4) - cyc_at(0)), 32'd4);
      check_eq("b2b_count", msg_count, 32'd5);
      check_eq("b2b_idle", 32'(outbox_state), 32'd0);

      // Reset while three messages are about to drain
      xb_wr_full = 1'b1;
      for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i));
      clear_got();
      xb_wr_full = 1'b0;
      RESET = 1'b1;
      step(1);
      @(negedge CLK);
      check_eq("mrst_wr_en", 32'(xb_wr_en), 32'd0);
      check_eq("mrst_count", msg_count, 32'd0);
      check_eq("mrst_full", 32'(fpga_msg_full), 32'd0);
      check_eq("mrst_state", 32'(outbox_state), 32'd0);
      RESET = 1'b0;
      step(6);
      check_eq("mrst_nodrain", 32'(got_q.size()), 32'd0);

      // Fill to the backpressure threshold while downstream is blocked
      xb_wr_full = 1'b1;
      for (int i = 0; i < 13; i++) push(32'h100 + 32'(i));
      @(negedge CLK);
      check_eq("thr_full13", 32'(fpga_msg_full), 32'd0);
      push(32'h10D);
      @(negedge CLK);
      check_eq("thr_full14", 32'(fpga_msg_full), 32'd1);
      check_eq("thr_state", 32'(outbox_state), 32'd2);
      check_eq("thr_ovf", 32'(overflow), 32'd0);
      check_eq("thr_occ", 32'(dut.count_q), 32'd14);
      clear_got();
      xb_wr_full = 1'b0;
      step(20);
      check_eq("thr_n", 32'(got_q.size()), 32'd14);
      check_eq("thr_first", got_at(0), 32'h100);
      check_eq("thr_last", got_at(13), 32'h10D);
      check_eq("thr_count", msg_count, 32'd14);

      // Push 17 ignoring backpressure: the 17th is dropped
      do_reset();
      xb_wr_full = 1'b1;
      for (int i = 1; i <= 17; i++) push(32'(i));
      @(negedge CLK);
      check_eq("ovf_occ", 32'(dut.count_q), 32'd16);
      check_eq("ovf_flag", 32'(overflow), 32'd1);
      check_eq("ovf_full", 32'(fpga_msg_full), 32'd1);
      clear_got();
      xb_wr_full = 1'b0;
      step(24);
      check_eq("ovf_n", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16; i++) check_eq("ovf_data", got_at(i), 32'(i + 1));
      check_eq("ovf_sticky", 32'(overflow), 32'd1);

      // Downstream full toggling every other cycle during a burst
      do_reset();
      clear_got();
      watch = 1'b1;
      for (int i = 0; i < 16; i++) begin
         xb_wr_full = (i % 2) == 1;
         push(32'h200 + 32'(i));
      end
      for (int j = 0; j < 20; j++) begin
         xb_wr_full = ~xb_wr_full;
         step(1);
      end
      xb_wr_full = 1'b0;
      step(4);
      watch = 1'b0;
      check_eq("tog_n", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16; i++) check_eq("tog_data", got_at(i), 32'h200 + 32'(i));
      check_eq("tog_viol", 32'(viol), 32'd0);
      check_eq("tog_alt", 32'(n_alt > 4), 32'd1);
      check_eq("tog_count", msg_count, 32'd16);

      // msg_count wraps through zero
      do_reset();
      force dut.msg_count_q = 32'hFFFF_FFFE;
      step(1);
      release dut.msg_count_q;
      @(negedge CLK);
      check_eq("wrap_pre", msg_count, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
      step(8);
      check_eq("wrap_count", msg_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
